detect_seq_ctrl: RTL
====================

Name: detect_seq_ctrl

Overview:
- Sequences the serial 1101 Mealy detector (`mealy`: clk, n_rst, i, o).
- Accepts a parallel word on a start pulse, flushes the detector to a known state, then shifts the word out MSB-first.
- Counts detector hits per word and reports the count with a done pulse.
- Sits between a register-style requester and the `mealy` instance, which it drives through `ser_out` / `det_in`.

Parameters:
- DATA_WIDTH, 8: bits per job word (legal range 2..32).
- FLUSH_CYCLES, 3: zero bits driven before payload to clear detector state; must be at least 2 for 1101.
- CNT_WIDTH, 4: width of the hit counter.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled on rising edge; ignored while busy=1.
- data_in  in  DATA_WIDTH  job word; latched on the accepted start edge.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- ser_out  out  1  serial bit driven into detector input i.
- ser_valid  out  1  high only while ser_out carries payload bits.
- det_in  in  1  detector Mealy output o, combinational from ser_out.
- hit_count  out  CNT_WIDTH  number of hits in the current or last job.
- overflow  out  1  sticky per job; set when a hit arrives with hit_count at its maximum.
- done  out  1  single-cycle pulse at job completion.

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE.
  - busy=0, ser_out=0, ser_valid=0, done=0, hit_count=0, overflow=0.
  - Internal shift register and bit counter cleared.
  - All outputs are registered; none depends combinationally on inputs.
- IDLE:
  - ser_out=0.
  - On an edge with start=1: latch data_in, clear hit_count and overflow, load bit counter with FLUSH_CYCLES-1, go to FLUSH.
- FLUSH:
  - ser_out=0, ser_valid=0; det_in is ignored.
  - Bit counter decrements each cycle.
  - When the counter reaches 0: load DATA_WIDTH-1 and go to SHIFT.
  - Lasts exactly FLUSH_CYCLES cycles.
- SHIFT:
  - ser_out = shift-register MSB, ser_valid=1.
  - Register shifts left one bit per edge (zero fill).
  - First payload bit is data_in[DATA_WIDTH-1], visible FLUSH_CYCLES cycles after the FLUSH-entry edge.
  - On each edge in SHIFT with det_in=1:
    - hit_count < max: increment hit_count.
    - hit_count = max: hold hit_count (saturate) and set overflow.
  - After DATA_WIDTH cycles go to DONE.
- DONE:
  - done=1 for one cycle; ser_out=0, ser_valid=0, busy=1; go to IDLE.
  - hit_count and overflow are held until the next accepted start.
- Job length: busy is high for exactly FLUSH_CYCLES+DATA_WIDTH+1 cycles.
- start while busy=1, including the DONE cycle: ignored; no queuing.
- start in the cycle after DONE is accepted, giving back-to-back jobs.
- Reset mid-job: immediate return to IDLE with reset values; the detector, on the same n_rst, also resets.
- data_in changes after acceptance have no effect.

Decomposition:
- Package detect_pkg:
  - state enum typedef ctrl_state_t {IDLE, FLUSH, SHIFT, DONE}, 2-bit encoding.
  - DEF_FLUSH_CYCLES=3.
  - DET_PATTERN=4'b1101, for bench reference models.
- One sub-module, piso_shift:
  - DATA_WIDTH-bit parallel-load, MSB-first shift register.
  - Inputs: load, shift_en, par_in. Output: ser_msb.
- The FSM, bit counter and hit counter stay in detect_seq_ctrl.

Test Plan (bench instantiates detect_seq_ctrl plus the real `mealy`, default parameters unless noted; all cycle counts below are for the defaults):
- Reset during idle and mid-SHIFT → all outputs 0 within the same time step; after release, busy=0 and hit_count=0.
- start, data_in=8'b11011011 → busy for 12 cycles; ser_out shows 0,0,0 then 1,1,0,1,1,0,1,1; hits occur on payload bits 3 and 6; done pulses once; hit_count=2, overflow=0.
- data_in=8'b00000000, then a back-to-back job with 8'b11111111 → hit_count=0 for both; second job's start accepted the cycle after done.
- Flush check: job 8'b00000111, then 8'b01000000 → the trailing 11 must not combine with the next word; second job hit_count=0.
- CNT_WIDTH=1, data_in=8'b11011011 → hit_count=1, overflow=1 after done.
- start pulsed at payload bit 4 of a running job, data_in changed → ignored; original word completes and yields the expected count; no extra done.

Source files
------------

// File: rtl/detect_pkg.sv
// detect_pkg: shared types and constants for the 1101 detector sequencer
// Contents: controller state encoding, default flush length, detected pattern.
package detect_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } ctrl_state_t;
   localparam int DEF_FLUSH_CYCLES = 3;
   localparam logic [3:0] DET_PATTERN = 4'b1101;
endpackage

// File: rtl/mealy.sv
// mealy: overlapping 1101 Mealy sequence detector
// Ports: clk, n_rst (async active-low), i serial input, o asserted combinationally
// when i completes 1101 on the current cycle.
module mealy (
   input  logic clk,
   input  logic n_rst,
   input  logic i,
   output logic o
);
   localparam logic [1:0] S0 = 2'd0, S1 = 2'd1, S11 = 2'd2, S110 = 2'd3;
   logic [1:0] s_q, s_d;
   always_comb begin
      s_d = S0;
      case (s_q)
         S0:   s_d = i ? S1  : S0;
         S1:   s_d = i ? S11 : S0;
         S11:  s_d = i ? S11 : S110;
         S110: s_d = i ? S1  : S0;
      endcase
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) s_q <= S0;
      else s_q <= s_d;
   assign o = (s_q == S110) & i;
endmodule

// File: rtl/piso_shift.sv
// piso_shift: parallel-load, MSB-first shift register with zero fill
// Ports: clk, n_rst (async active-low), load (takes par_in, wins over shift),
// shift_en (shift left one bit), par_in parallel word, ser_msb current MSB.
module piso_shift #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  load,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] par_in,
   output logic                  ser_msb
);
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   always_comb
      sh_d = load ? par_in : shift_en ? {sh_q[DATA_WIDTH-2:0], 1'b0} : sh_q;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) sh_q <= '0;
      else sh_q <= sh_d;
   assign ser_msb = sh_q[DATA_WIDTH-1];
endmodule

// File: rtl/detect_seq_ctrl.sv
// detect_seq_ctrl: feeds a word MSB-first through the 1101 detector and counts hits
// Ports: clk, n_rst (async active-low), start/data_in job request and word,
// busy job in progress, ser_out/ser_valid serial stream to the detector,
// det_in detector output, hit_count/overflow per-job result, done completion pulse.
module detect_seq_ctrl
   import detect_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
   parameter int CNT_WIDTH    = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  busy,
   output logic                  ser_out,
   output logic                  ser_valid,
   input  logic                  det_in,
   output logic [CNT_WIDTH-1:0]  hit_count,
   output logic                  overflow,
   output logic                  done
);
   // One counter serves both phases, so size it for the longer one.
   localparam int BW = $clog2(DATA_WIDTH > FLUSH_CYCLES ? DATA_WIDTH : FLUSH_CYCLES);
   ctrl_state_t state_q, state_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] hit_q, hit_d;
   logic ovf_q, ovf_d;
   logic load, shift_en, ser_msb;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hit_d    = hit_q;
      ovf_d    = ovf_q;
      load     = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            load    = 1'b1;
            hit_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = BW'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
         end
         FLUSH: begin
            cnt_d   = (cnt_q == '0) ? BW'(DATA_WIDTH - 1) : cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? SHIFT : FLUSH;
         end
         SHIFT: begin
            shift_en = 1'b1;
            // Saturate at all-ones; a hit beyond that only marks overflow.
            if (det_in) begin
               hit_d = (&hit_q) ? hit_q : hit_q + 1'b1;
               ovf_d = ovf_q | (&hit_q);
            end
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? DONE : SHIFT;
         end
         DONE: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hit_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
         ovf_q   <= ovf_d;
      end
   piso_shift #(.DATA_WIDTH(DATA_WIDTH)) u_piso (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (load),
      .shift_en (shift_en),
      .par_in   (data_in),
      .ser_msb  (ser_msb)
   );
   // Outputs decode flops only, never inputs.
   assign busy      = state_q != IDLE;
   assign ser_valid = state_q == SHIFT;
   assign ser_out   = ser_valid & ser_msb;
   assign done      = state_q == DONE;
   assign hit_count = hit_q;
   assign overflow  = ovf_q;
endmodule
